// File: rtl/lbu_ptr_ctrl.sv
// lbu_ptr_ctrl -- loop-buffer pointer controller.
//
// Holds per-context pointer state (ptr/start/end/stride/waen). It hands
// operands to an external pointer updater and commits the updater's result.
// There are two stages:
//   S1     : captured op; upd_* operands driven combinationally from it.
//   Result : registered res_* with valid/ready back-pressure.
//
// Optional build macro:
//   LBU_PTR_CTRL_BOUNDS_CHK_EN - reject an lbset whose start > end (signed).
//   In the default build this macro is undefined and lbset always writes.
module lbu_ptr_ctrl #(
  parameter int P_IDS    = 4,
  parameter int P_ID_W   = 2,
  parameter int P_PTR    = 24,
  parameter int P_STRIDE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [P_ID_W-1:0]   op_id,
  input  logic [2:0]          op_mode,
  input  logic                op_lbset,
  input  logic                op_waen,
  input  logic [P_STRIDE-1:0] op_stride,
  input  logic [P_PTR-1:0]    op_start,
  input  logic [P_PTR-1:0]    op_end,
  output logic [2:0]          upd_mode,
  output logic                upd_waEn,
  output logic                upd_lbsetEn,
  output logic [P_STRIDE-1:0] upd_stride,
  output logic [P_PTR-1:0]    upd_start,
  output logic [P_PTR-1:0]    upd_end,
  output logic [P_PTR-1:0]    upd_rptr,
  input  logic [P_PTR-1:0]    upd_ptr,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [P_ID_W-1:0]   res_id,
  output logic [P_PTR-1:0]    res_ptr,
  output logic                res_err
);

  // Per-context state
  logic [P_PTR-1:0]    ptr_q    [P_IDS];
  logic [P_PTR-1:0]    ptr_d    [P_IDS];
  logic [P_PTR-1:0]    start_q  [P_IDS];
  logic [P_PTR-1:0]    start_d  [P_IDS];
  logic [P_PTR-1:0]    end_q    [P_IDS];
  logic [P_PTR-1:0]    end_d    [P_IDS];
  logic [P_STRIDE-1:0] stride_q [P_IDS];
  logic [P_STRIDE-1:0] stride_d [P_IDS];
  logic                waen_q   [P_IDS];
  logic                waen_d   [P_IDS];

  // S1 stage
  logic                s1_valid_q,  s1_valid_d;
  logic [P_ID_W-1:0]   s1_id_q,     s1_id_d;
  logic [2:0]          s1_mode_q,   s1_mode_d;
  logic                s1_lbset_q,  s1_lbset_d;
  logic                s1_waen_q,   s1_waen_d;
  logic [P_STRIDE-1:0] s1_stride_q, s1_stride_d;
  logic [P_PTR-1:0]    s1_start_q,  s1_start_d;
  logic [P_PTR-1:0]    s1_end_q,    s1_end_d;

  // Result stage
  logic                res_valid_q, res_valid_d;
  logic [P_ID_W-1:0]   res_id_q,    res_id_d;
  logic [P_PTR-1:0]    res_ptr_q,   res_ptr_d;
  logic                res_err_q,   res_err_d;

  // Combinational helpers
  logic                id_ok_s;
  logic                mode_wr_s;
  logic                bnd_fail_s;
  logic                adv_s;
  logic                wr_s;
  logic                accept_s;
  logic                op_ready_s;
  logic [P_PTR-1:0]    rptr_s;
  logic [P_PTR-1:0]    cfg_start_s;
  logic [P_PTR-1:0]    cfg_end_s;
  logic [P_STRIDE-1:0] cfg_stride_s;
  logic                cfg_waen_s;

  // Read the stored context of the S1 id (an AND-OR mux; out-of-range ids read as zero)
  always_comb begin
    rptr_s       = {P_PTR{1'b0}};
    cfg_start_s  = {P_PTR{1'b0}};
    cfg_end_s    = {P_PTR{1'b0}};
    cfg_stride_s = {P_STRIDE{1'b0}};
    cfg_waen_s   = 1'b0;
    for (int i = 0; i < P_IDS; i++) begin
      rptr_s       = rptr_s       | (ptr_q[i]    & {P_PTR{s1_id_q == P_ID_W'(i)}});
      cfg_start_s  = cfg_start_s  | (start_q[i]  & {P_PTR{s1_id_q == P_ID_W'(i)}});
      cfg_end_s    = cfg_end_s    | (end_q[i]    & {P_PTR{s1_id_q == P_ID_W'(i)}});
      cfg_stride_s = cfg_stride_s | (stride_q[i] & {P_STRIDE{s1_id_q == P_ID_W'(i)}});
      cfg_waen_s   = cfg_waen_s   | (waen_q[i]   & (s1_id_q == P_ID_W'(i)));
    end
  end

  // Classify the S1 op and derive handshake/advance conditions
  always_comb begin
    id_ok_s   = (32'(s1_id_q) < P_IDS);
    mode_wr_s = s1_lbset_q || (s1_mode_q == 3'd1) || (s1_mode_q == 3'd2) || (s1_mode_q == 3'd3);
`ifdef LBU_PTR_CTRL_BOUNDS_CHK_EN
    bnd_fail_s = s1_lbset_q && ($signed(s1_start_q) > $signed(s1_end_q));
`else
    bnd_fail_s = 1'b0;
`endif
    // S1 may retire whenever the result slot is free or being drained
    adv_s      = s1_valid_q && (!res_valid_q || res_ready);
    wr_s       = adv_s && id_ok_s && mode_wr_s && !bnd_fail_s;
    op_ready_s = !(s1_valid_q && res_valid_q && !res_ready);
    accept_s   = op_valid && op_ready_s;
  end

  // Drive updater operands from S1; lbset uses the captured config, others the stored one
  always_comb begin
    upd_mode    = 3'd0;
    upd_waEn    = 1'b0;
    upd_lbsetEn = 1'b0;
    upd_stride  = {P_STRIDE{1'b0}};
    upd_start   = {P_PTR{1'b0}};
    upd_end     = {P_PTR{1'b0}};
    upd_rptr    = {P_PTR{1'b0}};
    if (s1_valid_q) begin
      upd_mode    = s1_mode_q;
      upd_lbsetEn = s1_lbset_q;
      upd_rptr    = rptr_s;
      if (s1_lbset_q) begin
        upd_waEn   = s1_waen_q;
        upd_stride = s1_stride_q;
        upd_start  = s1_start_q;
        upd_end    = s1_end_q;
      end else begin
        upd_waEn   = cfg_waen_s;
        upd_stride = cfg_stride_s;
        upd_start  = cfg_start_s;
        upd_end    = cfg_end_s;
      end
    end else begin
      upd_mode = 3'd0;
    end
  end

  // Next state of the per-context registers: pointer on any write, config on lbset
  always_comb begin
    for (int i = 0; i < P_IDS; i++) begin
      if (wr_s && (s1_id_q == P_ID_W'(i))) begin
        ptr_d[i] = upd_ptr;
      end else begin
        ptr_d[i] = ptr_q[i];
      end
      if (wr_s && s1_lbset_q && (s1_id_q == P_ID_W'(i))) begin
        start_d[i]  = s1_start_q;
        end_d[i]    = s1_end_q;
        stride_d[i] = s1_stride_q;
        waen_d[i]   = s1_waen_q;
      end else begin
        start_d[i]  = start_q[i];
        end_d[i]    = end_q[i];
        stride_d[i] = stride_q[i];
        waen_d[i]   = waen_q[i];
      end
    end
  end

  // Next state of S1: load on accept, empty on retire, otherwise hold
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_mode_d   = s1_mode_q;
    s1_lbset_d  = s1_lbset_q;
    s1_waen_d   = s1_waen_q;
    s1_stride_d = s1_stride_q;
    s1_start_d  = s1_start_q;
    s1_end_d    = s1_end_q;
    if (accept_s) begin
      s1_valid_d  = 1'b1;
      s1_id_d     = op_id;
      s1_mode_d   = op_mode;
      s1_lbset_d  = op_lbset;
      s1_waen_d   = op_waen;
      s1_stride_d = op_stride;
      s1_start_d  = op_start;
      s1_end_d    = op_end;
    end else if (adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Next state of the result slot: capture on retire, drop on handshake, else hold stable
  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_ptr_d   = res_ptr_q;
    res_err_d   = res_err_q;
    if (adv_s) begin
      res_valid_d = 1'b1;
      res_id_d    = s1_id_q;
      if (!id_ok_s) begin
        res_ptr_d = {P_PTR{1'b0}};
        res_err_d = 1'b1;
      end else if (bnd_fail_s) begin
        res_ptr_d = rptr_s;
        res_err_d = 1'b1;
      end else if (mode_wr_s) begin
        res_ptr_d = upd_ptr;
        res_err_d = 1'b0;
      end else begin
        res_ptr_d = rptr_s;
        res_err_d = 1'b0;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Per-context register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_IDS; i++) begin
        ptr_q[i]    <= {P_PTR{1'b0}};
        start_q[i]  <= {P_PTR{1'b0}};
        end_q[i]    <= {P_PTR{1'b0}};
        stride_q[i] <= {P_STRIDE{1'b0}};
        waen_q[i]   <= 1'b0;
      end
    end else begin
      ptr_q    <= ptr_d;
      start_q  <= start_d;
      end_q    <= end_d;
      stride_q <= stride_d;
      waen_q   <= waen_d;
    end
  end

  // S1 stage register; reset drops any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= {P_ID_W{1'b0}};
      s1_mode_q   <= 3'd0;
      s1_lbset_q  <= 1'b0;
      s1_waen_q   <= 1'b0;
      s1_stride_q <= {P_STRIDE{1'b0}};
      s1_start_q  <= {P_PTR{1'b0}};
      s1_end_q    <= {P_PTR{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_mode_q   <= s1_mode_d;
      s1_lbset_q  <= s1_lbset_d;
      s1_waen_q   <= s1_waen_d;
      s1_stride_q <= s1_stride_d;
      s1_start_q  <= s1_start_d;
      s1_end_q    <= s1_end_d;
    end
  end

  // Result register; reset discards any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_id_q    <= {P_ID_W{1'b0}};
      res_ptr_q   <= {P_PTR{1'b0}};
      res_err_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_ptr_q   <= res_ptr_d;
      res_err_q   <= res_err_d;
    end
  end

  assign op_ready  = op_ready_s;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_ptr   = res_ptr_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_lbu_ptr_ctrl.sv
// Testbench for lbu_ptr_ctrl. This file provides:
//   - a behavioural pointer updater that closes the upd_* loop;
//   - directed ops whose expected results are queued when each op is issued;
//   - a monitor that pops the queue and compares on every result handshake.
module tb_lbu_ptr_ctrl;

  localparam int IDS = 4;
  localparam int IDW = 3;
  localparam int PW  = 24;
  localparam int SW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [IDW-1:0] op_id;
  logic [2:0]    op_mode;
  logic          op_lbset;
  logic          op_waen;
  logic [SW-1:0] op_stride;
  logic [PW-1:0] op_start;
  logic [PW-1:0] op_end;
  logic [2:0]    upd_mode;
  logic          upd_waEn;
  logic          upd_lbsetEn;
  logic [SW-1:0] upd_stride;
  logic [PW-1:0] upd_start;
  logic [PW-1:0] upd_end;
  logic [PW-1:0] upd_rptr;
  logic [PW-1:0] upd_ptr;
  logic          res_valid;
  logic          res_ready;
  logic [IDW-1:0] res_id;
  logic [PW-1:0] res_ptr;
  logic          res_err;

  typedef struct {
    logic [IDW-1:0] id;
    logic [PW-1:0]  ptr;
    logic           err;
    bit             b2b;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic [PW-1:0] mdl;

  lbu_ptr_ctrl #(.P_IDS(IDS), .P_ID_W(IDW), .P_PTR(PW), .P_STRIDE(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_id(op_id), .op_mode(op_mode),
    .op_lbset(op_lbset), .op_waen(op_waen), .op_stride(op_stride),
    .op_start(op_start), .op_end(op_end),
    .upd_mode(upd_mode), .upd_waEn(upd_waEn), .upd_lbsetEn(upd_lbsetEn),
    .upd_stride(upd_stride), .upd_start(upd_start), .upd_end(upd_end),
    .upd_rptr(upd_rptr), .upd_ptr(upd_ptr),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_ptr(res_ptr), .res_err(res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural updater: lbset/Rst load start, Incr/Decr step with optional wrap
  always_comb begin
    mdl = upd_rptr;
    if (upd_lbsetEn) begin
      mdl = upd_start;
    end else begin
      case (upd_mode)
        3'd1: mdl = upd_start;
        3'd2: begin
          mdl = upd_rptr + {{(PW-SW){upd_stride[SW-1]}}, upd_stride};
          if (upd_waEn && ($signed(mdl) > $signed(upd_end))) mdl = upd_start;
        end
        3'd3: begin
          mdl = upd_rptr - {{(PW-SW){upd_stride[SW-1]}}, upd_stride};
          if (upd_waEn && ($signed(mdl) < $signed(upd_start))) mdl = upd_end;
        end
        default: mdl = upd_rptr;
      endcase
    end
    upd_ptr = mdl;
  end

  // Monitor: compare each accepted result against the head of the queue
  always begin
    @(negedge clk);
    #2;
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result id=%0d ptr=%0d err=%0d", res_id, res_ptr, res_err);
      end else begin
        mon_e = q.pop_front();
        if (res_id !== mon_e.id || res_ptr !== mon_e.ptr || res_err !== mon_e.err) begin
          errors++;
          $display("FAIL result got id=%0d ptr=%0d err=%0d expected id=%0d ptr=%0d err=%0d",
                   res_id, res_ptr, res_err, mon_e.id, mon_e.ptr, mon_e.err);
        end
        if (mon_e.b2b) begin
          checks++;
          if (cyc != last_cyc + 1) begin
            errors++;
            $display("FAIL throughput got gap=%0d expected gap=1", cyc - last_cyc);
          end
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Present an op, wait (bounded) for op_ready, queue its expected result
  task automatic send(input logic [IDW-1:0] id, input logic [2:0] mode, input logic lb,
                      input logic wa, input logic [SW-1:0] st, input logic [PW-1:0] s,
                      input logic [PW-1:0] e, input logic [PW-1:0] ep, input logic ee,
                      input bit b2b);
    int n;
    exp_t x;
    op_valid = 1'b1; op_id = id; op_mode = mode; op_lbset = lb; op_waen = wa;
    op_stride = st; op_start = s; op_end = e;
    #1;
    n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (op_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL op_accept_timeout got=%0d expected=1", op_ready);
      op_valid = 1'b0;
    end else begin
      x.id = id; x.ptr = ep; x.err = ee; x.b2b = b2b;
      q.push_back(x);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    op_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_id = '0; op_mode = 3'd0; op_lbset = 1'b0;
    op_waen = 1'b0; op_stride = '0; op_start = '0; op_end = '0; res_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_upd_rptr", upd_rptr, 0);
    chk("rst_res_err", res_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read id0 after reset
    send(3'd0, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b0, 1'b0);
    // lbset id1 then three back-to-back Incr
    send(3'd1, 3'd0, 1'b1, 1'b1, 8'd8, 24'd100, 24'd200, 24'd100, 1'b0, 1'b0);
    send(3'd1, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd108, 1'b0, 1'b1);
    send(3'd1, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd116, 1'b0, 1'b1);
    send(3'd1, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd124, 1'b0, 1'b1);
    // Decr id1 uses the stored stride; inspect the updater operands in S1
    send(3'd1, 3'd3, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd116, 1'b0, 1'b0);
    op_valid = 1'b0;
    #1;
    chk("decr_upd_mode", upd_mode, 3);
    chk("decr_upd_rptr", upd_rptr, 124);
    chk("decr_upd_stride", upd_stride, 8);
    chk("decr_upd_start", upd_start, 100);
    chk("decr_upd_lbsetEn", upd_lbsetEn, 0);
    @(negedge clk);
    // Mode 5 behaves as None
    send(3'd1, 3'd5, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd116, 1'b0, 1'b0);
    drain();

    // Back-pressure: two Incr while the result slot is stalled
    res_ready = 1'b0;
    send(3'd1, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd124, 1'b0, 1'b0);
    send(3'd1, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd132, 1'b0, 1'b0);
    op_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_op_ready", op_ready, 0);
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_ptr", res_ptr, 124);
      chk("stall_res_id", res_id, 1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    drain();

    // Rst reloads start
    send(3'd1, 3'd1, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd100, 1'b0, 1'b0);
    // lbset with start > end, then Incr to expose the stored config
`ifdef LBU_PTR_CTRL_BOUNDS_CHK_EN
    send(3'd2, 3'd0, 1'b1, 1'b0, 8'd4, 24'd50, 24'd10, 24'd0, 1'b1, 1'b0);
    send(3'd2, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b0, 1'b0);
    op_valid = 1'b0;
    #1;
    chk("bad_lbset_upd_start", upd_start, 0);
`else
    send(3'd2, 3'd0, 1'b1, 1'b0, 8'd4, 24'd50, 24'd10, 24'd50, 1'b0, 1'b0);
    send(3'd2, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd54, 1'b0, 1'b0);
    op_valid = 1'b0;
    #1;
    chk("lbset_upd_start", upd_start, 50);
`endif
    @(negedge clk);
    // Out-of-range ids are rejected and write nothing
    send(3'd5, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b1, 1'b0);
    send(3'd6, 3'd0, 1'b1, 1'b1, 8'd3, 24'd1, 24'd2, 24'd0, 1'b1, 1'b0);
    send(3'd1, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd100, 1'b0, 1'b0);
`ifdef LBU_PTR_CTRL_BOUNDS_CHK_EN
    send(3'd2, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b0, 1'b0);
`else
    send(3'd2, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd54, 1'b0, 1'b0);
`endif
    drain();

    // Reset while an Incr id1 sits in S1: discarded, ptr cleared
    send(3'd1, 3'd2, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd108, 1'b0, 1'b0);
    op_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_op_ready", op_ready, 1);
    chk("midrst_upd_rptr", upd_rptr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("postrst_res_valid", res_valid, 0);
    @(negedge clk);
    send(3'd1, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b0, 1'b0);
    send(3'd2, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b0, 1'b0);
    send(3'd5, 3'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0, 24'd0, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
